// File: rtl/ifetch_lb_pkg.sv
// Shared widths, FSM states and entry layout for the instruction-fetch line buffer.
package ifetch_lb_pkg;
  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;
  localparam int OFFSET_W  = 5;
  localparam int WIDX_W    = 3;
  localparam int TAG_W     = 32 - OFFSET_W;
  localparam int CNT_W     = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESP_HIT  = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    RESP_MISS = 3'd4
  } lb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] data;
  } lb_entry_t;

  // Word w of a line occupies bits [w*32 +: 32].
  function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                            input logic [WIDX_W-1:0]    w);
    return line[{w, 5'b0} +: 32];
  endfunction
endpackage

// File: rtl/ifetch_line_buffer_lb_burst_assembler.sv
// Collects the beats of one burst into a line; beats tagged with another line address are dropped.
module lb_burst_assembler
  import ifetch_lb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 active,
  input  logic [31:0]          line_addr,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid,
  output logic [LINE_BITS-1:0] line,
  output logic                 done
);
  logic [CNT_W-1:0] cnt;
  logic             take;

  assign take = active && bmem_rvalid && (bmem_raddr == line_addr);
  assign done = take && (cnt == CNT_W'(BEATS - 1));

  // Shifting in from the top leaves beat b at bits [b*64 +: 64] after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      line <= '0;
    end else begin
      if (start)
        cnt <= '0;
      else if (take)
        cnt <= cnt + CNT_W'(1);
      if (take)
        line <= {bmem_rdata, line[LINE_BITS-1:BEAT_BITS]};
    end
  end
endmodule

// File: rtl/ifetch_line_buffer.sv
// Fully-associative line buffer serving single-word reads; misses fill a whole line with a 4-beat burst.
module ifetch_line_buffer
  import ifetch_lb_pkg::*;
#(
  parameter int NUM_LINES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [31:0]          req_addr,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [31:0]          resp_data,
  output logic                 miss_seen,
  input  logic                 flush,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);
  localparam int PTR_W = $clog2(NUM_LINES);

  lb_state_t            state, state_n;
  lb_entry_t            entries [NUM_LINES];
  logic [31:2]          lat_addr;
  logic [31:0]          line_addr;
  logic [PTR_W-1:0]     rr_ptr, hit_idx, hit_idx_c, victim;
  logic                 hit_c, all_valid;
  logic                 accept, install, fill_start, asm_done;
  logic                 miss_first, flush_pend;
  logic [LINE_BITS-1:0] asm_line;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];
  assign line_addr = {lat_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign miss_seen = miss_first;

  // A flush arriving with the request wins: the lookup sees every entry as invalid.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (entries[i].valid && !flush && entries[i].tag == req_addr[31:OFFSET_W]) begin
        hit_c     = 1'b1;
        hit_idx_c = PTR_W'(i);
      end
    end
  end

  always_comb begin
    victim    = rr_ptr;
    all_valid = 1'b1;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        victim    = PTR_W'(i);
        all_valid = 1'b0;
      end
    end
  end

  always_comb begin
    state_n    = state;
    resp_valid = 1'b0;
    resp_data  = '0;
    bmem_read  = 1'b0;
    bmem_addr  = '0;
    fill_start = 1'b0;
    install    = 1'b0;
    case (state)
      IDLE:
        if (accept) state_n = hit_c ? RESP_HIT : FILL_REQ;
      RESP_HIT: begin
        resp_valid = 1'b1;
        resp_data  = line_word(entries[hit_idx].data, lat_addr[4:2]);
        state_n    = IDLE;
      end
      FILL_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = line_addr;
        if (bmem_ready) begin
          fill_start = 1'b1;
          state_n    = FILL_WAIT;
        end
      end
      FILL_WAIT:
        if (asm_done) state_n = RESP_MISS;
      RESP_MISS: begin
        resp_valid = 1'b1;
        resp_data  = line_word(asm_line, lat_addr[4:2]);
        install    = !flush_pend && !flush;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      hit_idx    <= '0;
      rr_ptr     <= '0;
      miss_first <= 1'b0;
      flush_pend <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) entries[i].valid <= 1'b0;
    end else begin
      state      <= state_n;
      miss_first <= accept && !hit_c;
      if (accept) begin
        lat_addr <= req_addr[31:2];
        hit_idx  <= hit_idx_c;
      end
      // A line fetched across a flush may be stale, so it is returned but never kept.
      if (state == IDLE)
        flush_pend <= 1'b0;
      else if (flush && (state == FILL_REQ || state == FILL_WAIT))
        flush_pend <= 1'b1;
      if (flush) begin
        for (int i = 0; i < NUM_LINES; i++) entries[i].valid <= 1'b0;
        rr_ptr <= '0;
      end else if (install) begin
        entries[victim] <= '{valid: 1'b1, tag: lat_addr[31:OFFSET_W], data: asm_line};
        if (all_valid) rr_ptr <= rr_ptr + PTR_W'(1);
      end
    end
  end

  lb_burst_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .start      (fill_start),
    .active     (state == FILL_WAIT),
    .line_addr  (line_addr),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .line       (asm_line),
    .done       (asm_done)
  );
endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Bench for ifetch_line_buffer: directed scenarios plus randomized traffic against a cache model.
module tb_ifetch_line_buffer;
  localparam int NL = 2;

  logic        clk, rst;
  logic        req_valid, req_ready, resp_valid, miss_seen, flush;
  logic [31:0] req_addr, resp_data, bmem_addr, bmem_raddr;
  logic        bmem_read, bmem_ready, bmem_rvalid;
  logic [63:0] bmem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a set of remembered lines with lowest-free / round-robin replacement.
  bit           mv [NL];
  logic [26:0]  mt [NL];
  logic [255:0] md [NL];
  int           mptr;

  ifetch_line_buffer #(.NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .miss_seen(miss_seen), .flush(flush),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic m_clear();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    mptr = 0;
  endtask

  task automatic m_lookup(input logic [31:0] a, output bit h, output logic [255:0] d);
    h = 1'b0;
    d = '0;
    for (int i = 0; i < NL; i++)
      if (mv[i] && mt[i] == a[31:5]) begin h = 1'b1; d = md[i]; end
  endtask

  task automatic m_install(input logic [31:0] a, input logic [255:0] line);
    int slot = -1;
    for (int i = NL - 1; i >= 0; i--) if (!mv[i]) slot = i;
    if (slot < 0) begin
      slot = mptr;
      mptr = (mptr + 1) % NL;
    end
    mv[slot] = 1'b1;
    mt[slot] = a[31:5];
    md[slot] = line;
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] l, input logic [31:0] a);
    int wi;
    wi = int'(a[4:2]);
    return l[wi*32 +: 32];
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Drives one request and plays the memory side; returns what was observed.
  task automatic do_txn(input logic [31:0] addr, input int lat, input logic [255:0] line,
                        input bit foreign, input bit gaps, input int flush_at, input bit flush_with_req,
                        output bit rdy0, output bit got, output logic [31:0] rdata, output int misses,
                        output int rcyc, output int lastb, output bit rd_seen, output logic [31:0] baddr);
    int cyc = 0, w = 0, bi = 0;
    bit phase = 0, fsent = 0;
    got = 0; rdata = '0; misses = 0; rcyc = -1; lastb = -100; rd_seen = 0; baddr = '0;
    @(negedge clk);
    rdy0 = req_ready;
    req_valid = 1'b1;
    req_addr  = addr;
    flush     = flush_with_req;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      if (miss_seen) misses++;
      if (resp_valid) begin
        got = 1; rdata = resp_data; rcyc = cyc; req_valid = 1'b0;
      end else if (bmem_read) begin
        rd_seen = 1; baddr = bmem_addr;
        if (w >= lat) begin bmem_ready = 1'b1; phase = 1; end
        else w++;
      end else if (phase && bi < 4 && !(gaps && $urandom_range(0, 2) == 0)) begin
        if (foreign && bi == 1 && !fsent) begin
          bmem_raddr = 32'h0000_9000;
          bmem_rdata = {$urandom, $urandom};
          fsent = 1;
        end else begin
          bmem_raddr = {addr[31:5], 5'b0};
          bmem_rdata = line[bi*64 +: 64];
          if (flush_at == bi) flush = 1'b1;
          bi++;
          if (bi == 4) lastb = cyc;
        end
        bmem_rvalid = 1'b1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rdy_in_rst: got %b want 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_in_rst: got %b want 0", resp_valid); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b want 1", req_ready); end
    n_cmp++; if (miss_seen !== 1'b0) begin n_bad++; $display("FAIL reset_miss: got %b want 0", miss_seen); end
    n_cmp++; if (bmem_read !== 1'b0) begin n_bad++; $display("FAIL reset_bread: got %b want 0", bmem_read); end
    n_cmp++; if (bmem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_baddr: got %h want 0", bmem_addr); end
    m_clear();
  endtask

  task automatic test_cold_miss();
    logic [255:0] line;
    bit rdy0, got, rd; logic [31:0] rdata, baddr; int misses, rcyc, lastb;
    line = {64'h77777777_66666666, 64'h55555555_44444444, 64'h33333333_22222222, 64'h11111111_00000000};
    do_txn(32'h0000_1044, 2, line, 0, 0, -1, 0, rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
    n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL cold_rdy: got %b want 1", rdy0); end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL cold_resp: got %b want 1", got); end
    n_cmp++; if (baddr !== 32'h0000_1040) begin n_bad++; $display("FAIL cold_baddr: got %h want 00001040", baddr); end
    n_cmp++; if (misses != 1) begin n_bad++; $display("FAIL cold_miss_pulses: got %0d want 1", misses); end
    n_cmp++; if (rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL cold_data: got %h want 11111111", rdata); end
    n_cmp++; if (rcyc != lastb + 1) begin n_bad++; $display("FAIL cold_latency: got %0d want %0d", rcyc, lastb + 1); end
    m_install(32'h0000_1044, line);
  endtask

  task automatic test_hit();
    bit rdy0, got, rd; logic [31:0] rdata, baddr; int misses, rcyc, lastb;
    do_txn(32'h0000_105C, 0, '0, 0, 0, -1, 0, rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
    n_cmp++; if (rcyc != 1) begin n_bad++; $display("FAIL hit_latency: got %0d want 1", rcyc); end
    n_cmp++; if (rdata !== 32'h7777_7777) begin n_bad++; $display("FAIL hit_data: got %h want 77777777", rdata); end
    n_cmp++; if (rd !== 1'b0) begin n_bad++; $display("FAIL hit_bread: got %b want 0", rd); end
    n_cmp++; if (misses != 0) begin n_bad++; $display("FAIL hit_miss_pulses: got %0d want 0", misses); end
  endtask

  task automatic test_replacement();
    logic [31:0] addrs [5] = '{32'h0000_2040, 32'h0000_3040, 32'h0000_1044, 32'h0000_3048, 32'h0000_2044};
    int exp_miss [5] = '{1, 1, 1, 0, 1};
    bit rdy0, got, rd, h; logic [31:0] rdata, baddr; int misses, rcyc, lastb;
    logic [255:0] line, d;
    for (int i = 0; i < 5; i++) begin
      line = rand_line();
      m_lookup(addrs[i], h, d);
      do_txn(addrs[i], 1, line, 0, 0, -1, 0, rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
      n_cmp++; if (misses != exp_miss[i]) begin n_bad++; $display("FAIL repl_miss[%0d]: got %0d want %0d", i, misses, exp_miss[i]); end
      if (!h) d = line;
      n_cmp++; if (rdata !== word_of(d, addrs[i])) begin n_bad++; $display("FAIL repl_data[%0d]: got %h want %h", i, rdata, word_of(d, addrs[i])); end
      if (!h) m_install(addrs[i], line);
    end
  endtask

  task automatic test_foreign_beats();
    bit rdy0, got, rd; logic [31:0] rdata, baddr; int misses, rcyc, lastb;
    logic [255:0] line;
    line = rand_line();
    do_txn(32'h0000_5010, 1, line, 1, 1, -1, 0, rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
    n_cmp++; if (rdata !== word_of(line, 32'h0000_5010)) begin n_bad++; $display("FAIL foreign_data: got %h want %h", rdata, word_of(line, 32'h0000_5010)); end
    n_cmp++; if (rcyc != lastb + 1) begin n_bad++; $display("FAIL foreign_latency: got %0d want %0d", rcyc, lastb + 1); end
    m_install(32'h0000_5010, line);
  endtask

  task automatic test_flush_fill();
    bit rdy0, got, rd; logic [31:0] rdata, baddr; int misses, rcyc, lastb;
    logic [255:0] line;
    line = rand_line();
    do_txn(32'h0000_6008, 0, line, 0, 0, 2, 0, rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL flush_resp: got %b want 1", got); end
    n_cmp++; if (rdata !== word_of(line, 32'h0000_6008)) begin n_bad++; $display("FAIL flush_data: got %h want %h", rdata, word_of(line, 32'h0000_6008)); end
    m_clear();
    line = rand_line();
    do_txn(32'h0000_6008, 0, line, 0, 0, -1, 0, rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
    n_cmp++; if (misses != 1) begin n_bad++; $display("FAIL flush_rereq_miss: got %0d want 1", misses); end
    n_cmp++; if (rdata !== word_of(line, 32'h0000_6008)) begin n_bad++; $display("FAIL flush_rereq_data: got %h want %h", rdata, word_of(line, 32'h0000_6008)); end
    m_install(32'h0000_6008, line);
  endtask

  task automatic test_reset_mid_fill();
    bit rdy0, got, rd; logic [31:0] rdata, baddr; int misses, rcyc, lastb, cyc;
    logic [255:0] line;
    int spurious = 0;
    line = rand_line();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_7024;
    cyc = 0;
    while (!bmem_read && cyc < 20) begin @(negedge clk); cyc++; end
    n_cmp++; if (bmem_read !== 1'b1) begin n_bad++; $display("FAIL rstfill_bread: got %b want 1", bmem_read); end
    bmem_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      if (resp_valid) spurious++;
      bmem_ready = 1'b0; bmem_raddr = 32'h0000_7020; bmem_rdata = line[b*64 +: 64]; bmem_rvalid = 1'b1;
    end
    @(negedge clk);
    if (resp_valid) spurious++;
    bmem_rvalid = 1'b0; rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rstfill_rdy_in_rst: got %b want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstfill_rdy: got %b want 1", req_ready); end
    for (int b = 2; b < 4; b++) begin
      bmem_raddr = 32'h0000_7020; bmem_rdata = line[b*64 +: 64]; bmem_rvalid = 1'b1;
      @(negedge clk);
      if (resp_valid || bmem_read) spurious++;
    end
    bmem_rvalid = 1'b0;
    n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL rstfill_spurious: got %0d want 0", spurious); end
    m_clear();
    line = rand_line();
    do_txn(32'h0000_7024, 0, line, 0, 0, -1, 0, rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
    n_cmp++; if (misses != 1) begin n_bad++; $display("FAIL rstfill_rereq_miss: got %0d want 1", misses); end
    n_cmp++; if (rdata !== word_of(line, 32'h0000_7024)) begin n_bad++; $display("FAIL rstfill_rereq_data: got %h want %h", rdata, word_of(line, 32'h0000_7024)); end
    m_install(32'h0000_7024, line);
  endtask

  task automatic test_random();
    bit rdy0, got, rd, h, fwr; logic [31:0] rdata, baddr, a, expw; int misses, rcyc, lastb, fat;
    logic [255:0] line, d;
    for (int t = 0; t < 40; t++) begin
      a = (32'h1000 * $urandom_range(1, 3)) + 32'h40 + {$urandom_range(0, 7), 2'b00};
      line = rand_line();
      fwr = ($urandom_range(0, 7) == 0);
      if (fwr) m_clear();
      m_lookup(a, h, d);
      fat = (!h && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_txn(a, $urandom_range(0, 3), line, $urandom_range(0, 3) == 0, 1, fat, fwr,
             rdy0, got, rdata, misses, rcyc, lastb, rd, baddr);
      expw = h ? word_of(d, a) : word_of(line, a);
      n_cmp++; if (rdata !== expw) begin n_bad++; $display("FAIL rand_data[%0d] addr %h: got %h want %h", t, a, rdata, expw); end
      n_cmp++; if (misses != (h ? 0 : 1)) begin n_bad++; $display("FAIL rand_miss[%0d] addr %h: got %0d want %0d", t, a, misses, h ? 0 : 1); end
      n_cmp++; if (rcyc != (h ? 1 : lastb + 1)) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, rcyc, h ? 1 : lastb + 1); end
      if (!h) begin
        n_cmp++; if (baddr !== {a[31:5], 5'b0}) begin n_bad++; $display("FAIL rand_baddr[%0d]: got %h want %h", t, baddr, {a[31:5], 5'b0}); end
        if (fat >= 0) m_clear();
        else m_install(a, line);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_cold_miss();
    test_hit();
    test_replacement();
    test_foreign_beats();
    test_flush_fill();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
